// File: rtl/psx_timer_pkg.sv
// Shared constants and types for the PSX root-counter channel.
// Mode bit indices, register addresses, sync modes and a byte-merge helper.
package psx_timer_pkg;

    localparam int M_SYNC_EN  = 0;
    localparam int M_RST_TGT  = 3;
    localparam int M_IRQ_TGT  = 4;
    localparam int M_IRQ_OVF  = 5;
    localparam int M_REPEAT   = 6;
    localparam int M_TOGGLE   = 7;
    localparam int M_IRQ_N    = 10;
    localparam int M_HIT_TGT  = 11;
    localparam int M_HIT_OVF  = 12;

    localparam logic [1:0]  ADDR_COUNT  = 2'd0;
    localparam logic [1:0]  ADDR_MODE   = 2'd1;
    localparam logic [1:0]  ADDR_TARGET = 2'd2;

    localparam logic [15:0] WRAP_VAL = 16'hFFFF;
    localparam logic [12:0] MODE_RST = 13'h0400;

    typedef enum logic [1:0] {
        PAUSE_HI,
        RST_EDGE,
        RST_PAUSE_LO,
        WAIT_EDGE
    } sync_mode_t;

    function automatic logic [15:0] merge16(
        input logic [15:0] old,
        input logic [15:0] d,
        input logic [1:0]  be
    );
        merge16 = {be[1] ? d[15:8] : old[15:8],
                   be[0] ? d[7:0]  : old[7:0]};
    endfunction

endpackage

// File: rtl/psx_gate_sync.sv
// Gate history register for the root counter sync logic.
// Ports: sys_clk, rst_n, gate_i in; gate_lvl (current level), gate_rise out.
module psx_gate_sync (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic gate_i,
    output logic gate_lvl,
    output logic gate_rise
);

    logic gate_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) gate_q <= 1'b0;
        else        gate_q <= gate_i;
    end

    assign gate_lvl  = gate_i;
    assign gate_rise = gate_i & ~gate_q;

endmodule

// File: rtl/psx_root_counter.sv
// One PSX root-counter channel: count/mode/target registers and IRQ pulse.
// Ports: halfword register bus (wen/ren/ben/addr/data_i), tick_i, gate_i,
//        count_o/mode_o/target_o readback, irq_o one-cycle pulse.
module psx_root_counter
    import psx_timer_pkg::*;
#(
    parameter logic [15:0] TGT_RST_VAL = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  ben,
    input  logic [1:0]  addr,
    input  logic [15:0] data_i,
    input  logic        tick_i,
    input  logic        gate_i,
    output logic [31:0] count_o,
    output logic [31:0] mode_o,
    output logic [31:0] target_o,
    output logic        irq_o
);

    logic [15:0] count;
    logic [15:0] target;
    logic [12:0] mode;
    logic        armed;
    logic        irq_q;

    logic        gate_lvl;
    logic        gate_rise;

    psx_gate_sync u_gate (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .gate_i    (gate_i),
        .gate_lvl  (gate_lvl),
        .gate_rise (gate_rise)
    );

    logic wr_cnt, wr_mode, wr_tgt, rd_mode;

    assign wr_cnt  = wen & (addr == ADDR_COUNT);
    assign wr_mode = wen & (addr == ADDR_MODE);
    assign wr_tgt  = wen & (addr == ADDR_TARGET);
    assign rd_mode = ren & (addr == ADDR_MODE);

    sync_mode_t smode;
    logic       paused;
    logic       gate_rst;
    logic       sync_done;

    assign smode = sync_mode_t'(mode[2:1]);

    always_comb begin
        paused    = 1'b0;
        gate_rst  = 1'b0;
        sync_done = 1'b0;
        if (mode[M_SYNC_EN]) begin
            unique case (smode)
                PAUSE_HI:     paused = gate_lvl;
                RST_EDGE:     gate_rst = gate_rise;
                RST_PAUSE_LO: begin
                    gate_rst = gate_rise;
                    paused   = ~gate_lvl;
                end
                WAIT_EDGE:    begin
                    paused    = 1'b1;
                    sync_done = gate_rise;
                end
            endcase
        end
    end

    // A tick only lands when no bus write or gate reset claims the counter.
    logic        step;
    logic [15:0] nxt;
    logic        tgt_evt, ovf_evt;
    logic        irq_cond, fire, irq_n_nxt;

    assign step = tick_i & ~paused & ~wr_cnt & ~wr_mode & ~gate_rst;

    always_comb begin
        nxt = count + 16'd1;
        if (mode[M_RST_TGT] && (count == target)) nxt = '0;
    end

    assign tgt_evt  = step & (nxt == target);
    assign ovf_evt  = step & (nxt == WRAP_VAL);
    assign irq_cond = armed & ((tgt_evt & mode[M_IRQ_TGT]) |
                               (ovf_evt & mode[M_IRQ_OVF]));

    // Pulse mode suppresses back-to-back pulses; toggle fires on 1->0 only.
    always_comb begin
        if (mode[M_TOGGLE]) begin
            fire      = irq_cond & mode[M_IRQ_N];
            irq_n_nxt = mode[M_IRQ_N] ^ irq_cond;
        end else begin
            fire      = irq_cond & ~irq_q;
            irq_n_nxt = ~fire;
        end
    end

    logic [9:0] mode_wdat;

    assign mode_wdat = {ben[1] ? data_i[9:8] : mode[9:8],
                        ben[0] ? data_i[7:0] : mode[7:0]};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            target <= TGT_RST_VAL;
            mode   <= MODE_RST;
            armed  <= 1'b1;
            irq_q  <= 1'b0;
        end else begin
            if (wr_mode)       count <= '0;
            else if (wr_cnt)   count <= merge16(count, data_i, ben);
            else if (gate_rst) count <= '0;
            else if (step)     count <= nxt;

            if (wr_tgt) target <= merge16(target, data_i, ben);

            if (wr_mode) begin
                mode[9:0]     <= mode_wdat;
                mode[M_IRQ_N] <= 1'b1;
                armed         <= 1'b1;
            end else begin
                if (sync_done) mode[M_SYNC_EN] <= 1'b0;
                mode[M_IRQ_N] <= irq_n_nxt;
                if (fire && !mode[M_REPEAT]) armed <= 1'b0;
            end

            mode[M_HIT_TGT] <= tgt_evt | (mode[M_HIT_TGT] & ~rd_mode);
            mode[M_HIT_OVF] <= ovf_evt | (mode[M_HIT_OVF] & ~rd_mode);

            irq_q <= fire;
        end
    end

    assign count_o  = {16'b0, count};
    assign mode_o   = {19'b0, mode};
    assign target_o = {16'b0, target};
    assign irq_o    = irq_q;

endmodule
